// File: rtl/branch_update_arbiter.sv
// branch_update_arbiter: oldest-mispredict arbitration, registered flush, in-order BPU update FIFO
module branch_update_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd0_en,
    input  logic [31:0]      upd0_pc,
    input  logic             upd0_taken,
    input  logic             upd0_mispred,
    input  logic [31:0]      upd0_target,
    input  logic             upd1_en,
    input  logic [31:0]      upd1_pc,
    input  logic             upd1_taken,
    input  logic             upd1_mispred,
    input  logic [31:0]      upd1_target,
    input  logic             ex_flush_i,
    output logic             branch_flush_o,
    output logic [31:0]      flush_target_o,
    output logic             stall_o,
    output logic             bpu_valid,
    input  logic             bpu_ready,
    output logic [31:0]      bpu_pc,
    output logic             bpu_taken,
    output logic [31:0]      bpu_target,
    output logic [CNT_W-1:0] drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [AW:0] TWO = (AW+1)'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {NORMAL, SHADOW} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [AW:0]      free, enq_n, wr1;
    logic             flush_q, flush_d;
    logic [31:0]      target_q, target_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [1:0]       drops;
    logic             accept, kill1, m0, m1, q0, q1, e0, e1, deq;

    // Qualify inputs, arbitrate mispredicts, size the enqueue against pre-dequeue space
    always_comb begin
        accept   = !ex_flush_i && state_q == NORMAL;
        kill1    = upd0_en && upd0_mispred;
        m0       = accept && kill1;
        m1       = accept && !kill1 && upd1_en && upd1_mispred;
        q0       = accept && upd0_en;
        q1       = accept && upd1_en && !kill1;
        free     = DEPTH_W - count_q;
        e0       = q0 && free != '0;
        e1       = q1 && free >= (q0 ? TWO : ONE);
        deq      = bpu_valid && bpu_ready;
        enq_n    = (AW+1)'(e0) + (AW+1)'(e1);
        wr1      = wr_ptr_q + (AW+1)'(e0);
        wr_ptr_d = wr_ptr_q + enq_n;
        rd_ptr_d = rd_ptr_q + (AW+1)'(deq);
        count_d  = count_q + enq_n - (AW+1)'(deq);
        drops    = 2'(q0 && !e0) + 2'(q1 && !e1);
        drop_d   = (drop_q > CNT_MAX - CNT_W'(drops)) ? CNT_MAX : drop_q + CNT_W'(drops);
        state_d  = (state_q == NORMAL && (m0 || m1)) ? SHADOW : NORMAL;
        flush_d  = m0 || m1;
        target_d = m0 ? upd0_target : m1 ? upd1_target : target_q;
    end

    // Control state, flush pulse, pointers and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= NORMAL;
            flush_q  <= 1'b0;
            target_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            target_q <= target_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Entry storage; slot 0 lands before slot 1 so program order is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (e0) mem_q[wr_ptr_q[AW-1:0]] <= '{upd0_pc, upd0_taken, upd0_target};
            if (e1) mem_q[wr1[AW-1:0]] <= '{upd1_pc, upd1_taken, upd1_target};
        end
    end

    assign branch_flush_o = flush_q;
    assign flush_target_o = target_q;
    assign stall_o        = free < TWO;
    assign bpu_valid      = count_q != '0;
    assign bpu_pc         = mem_q[rd_ptr_q[AW-1:0]].pc;
    assign bpu_taken      = mem_q[rd_ptr_q[AW-1:0]].taken;
    assign bpu_target     = mem_q[rd_ptr_q[AW-1:0]].target;
    assign drop_cnt_o     = drop_q;
endmodule

// File: tb/tb_branch_update_arbiter.sv
// tb_branch_update_arbiter: directed self-checking bench for branch_update_arbiter
module tb_branch_update_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        upd0_en = 0, upd0_taken = 0, upd0_mispred = 0;
    logic        upd1_en = 0, upd1_taken = 0, upd1_mispred = 0;
    logic [31:0] upd0_pc = 0, upd0_target = 0, upd1_pc = 0, upd1_target = 0;
    logic        ex_flush_i = 0, bpu_ready = 0;
    logic        branch_flush_o, stall_o, bpu_valid, bpu_taken;
    logic [31:0] flush_target_o, bpu_pc, bpu_target;
    logic [15:0] drop_cnt_o;
    int checks = 0, errors = 0;

    branch_update_arbiter #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .upd0_en(upd0_en), .upd0_pc(upd0_pc), .upd0_taken(upd0_taken),
        .upd0_mispred(upd0_mispred), .upd0_target(upd0_target),
        .upd1_en(upd1_en), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken),
        .upd1_mispred(upd1_mispred), .upd1_target(upd1_target),
        .ex_flush_i(ex_flush_i), .branch_flush_o(branch_flush_o),
        .flush_target_o(flush_target_o), .stall_o(stall_o),
        .bpu_valid(bpu_valid), .bpu_ready(bpu_ready), .bpu_pc(bpu_pc),
        .bpu_taken(bpu_taken), .bpu_target(bpu_target), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic s0(input logic en, input logic [31:0] pc, input logic tk, input logic mp, input logic [31:0] tg);
        upd0_en = en; upd0_pc = pc; upd0_taken = tk; upd0_mispred = mp; upd0_target = tg;
    endtask

    task automatic s1(input logic en, input logic [31:0] pc, input logic tk, input logic mp, input logic [31:0] tg);
        upd1_en = en; upd1_pc = pc; upd1_taken = tk; upd1_mispred = mp; upd1_target = tg;
    endtask

    task automatic idle();
        s0(0, 0, 0, 0, 0);
        s1(0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_flush", 32'(branch_flush_o), 0);
        chk("rst_target", flush_target_o, 0);
        chk("rst_valid", 32'(bpu_valid), 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_drop", 32'(drop_cnt_o), 0);
        chk("rst_bpu_pc", bpu_pc, 0);
        rst_n = 1'b1;
        cyc();

        s0(1, 32'h1c000010, 1, 1, 32'h1c000100);
        s1(1, 32'h1c000014, 1, 1, 32'h1c000200);
        cyc(); idle();
        chk("s0kill_flush", 32'(branch_flush_o), 1);
        chk("s0kill_target", flush_target_o, 32'h1c000100);
        chk("s0kill_head_pc", bpu_pc, 32'h1c000010);
        chk("s0kill_head_tk", 32'(bpu_taken), 1);
        chk("s0kill_head_tg", bpu_target, 32'h1c000100);
        cyc();
        chk("s0kill_pulse_end", 32'(branch_flush_o), 0);
        bpu_ready = 1;
        cyc(); bpu_ready = 0;
        chk("s0kill_one_entry", 32'(bpu_valid), 0);

        s0(1, 32'h1c000020, 0, 0, 32'h1c000024);
        s1(1, 32'h1c000030, 1, 1, 32'h1c000040);
        cyc(); idle();
        chk("s1mp_flush", 32'(branch_flush_o), 1);
        chk("s1mp_target", flush_target_o, 32'h1c000040);
        chk("s1mp_head0", bpu_pc, 32'h1c000020);
        chk("s1mp_head0_tk", 32'(bpu_taken), 0);
        bpu_ready = 1;
        cyc();
        chk("s1mp_head1", bpu_pc, 32'h1c000030);
        chk("s1mp_head1_tk", 32'(bpu_taken), 1);
        chk("s1mp_pulse_end", 32'(branch_flush_o), 0);
        cyc(); bpu_ready = 0;
        chk("s1mp_empty", 32'(bpu_valid), 0);

        s0(1, 32'h1c000050, 1, 1, 32'h1c000500);
        cyc();
        s0(1, 32'h1c000060, 1, 1, 32'h1c000300);
        chk("shadow_flush", 32'(branch_flush_o), 1);
        chk("shadow_target", flush_target_o, 32'h1c000500);
        cyc(); idle();
        chk("shadow_no_second", 32'(branch_flush_o), 0);
        chk("shadow_head", bpu_pc, 32'h1c000050);
        bpu_ready = 1;
        cyc(); bpu_ready = 0;
        chk("shadow_one_entry", 32'(bpu_valid), 0);

        s0(1, 32'h1c001000, 0, 0, 32'h1c001100);
        cyc();
        chk("full_stall_c1", 32'(stall_o), 0);
        s0(1, 32'h1c001004, 0, 0, 32'h1c001104);
        cyc();
        chk("full_stall_c2", 32'(stall_o), 0);
        s0(1, 32'h1c001008, 0, 0, 32'h1c001108);
        cyc();
        chk("full_stall_c3", 32'(stall_o), 1);
        s0(1, 32'h1c00100c, 0, 0, 32'h1c00110c);
        s1(1, 32'h1c001010, 0, 0, 32'h1c001110);
        cyc();
        chk("full_drop1", 32'(drop_cnt_o), 1);
        chk("full_stall_c4", 32'(stall_o), 1);
        s0(1, 32'h1c001014, 0, 0, 32'h1c001114);
        s1(0, 0, 0, 0, 0);
        cyc(); idle();
        chk("full_drop2", 32'(drop_cnt_o), 2);
        bpu_ready = 1;
        chk("drain0", bpu_pc, 32'h1c001000);
        cyc();
        chk("drain1", bpu_pc, 32'h1c001004);
        cyc();
        chk("drain2", bpu_pc, 32'h1c001008);
        cyc();
        chk("drain3", bpu_pc, 32'h1c00100c);
        chk("drain3_tg", bpu_target, 32'h1c00110c);
        cyc(); bpu_ready = 0;
        chk("drain_empty", 32'(bpu_valid), 0);

        ex_flush_i = 1;
        s0(1, 32'h1c002000, 1, 1, 32'h1c002100);
        cyc(); idle(); ex_flush_i = 0;
        chk("ex_no_flush", 32'(branch_flush_o), 0);
        chk("ex_no_enq", 32'(bpu_valid), 0);
        s0(1, 32'h1c002200, 1, 1, 32'h1c002300);
        cyc(); idle();
        chk("ex_shadow_flush", 32'(branch_flush_o), 1);
        ex_flush_i = 1;
        cyc(); ex_flush_i = 0;
        chk("ex_shadow_clear", 32'(branch_flush_o), 0);
        chk("ex_shadow_head", bpu_pc, 32'h1c002200);

        s0(1, 32'h1c003000, 0, 0, 32'h1c003004);
        cyc();
        s0(1, 32'h1c003008, 1, 1, 32'h1c003100);
        cyc(); idle();
        chk("prerst_flush", 32'(branch_flush_o), 1);
        chk("prerst_stall", 32'(stall_o), 1);
        chk("prerst_drop", 32'(drop_cnt_o), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bpu_valid), 0);
        chk("arst_flush", 32'(branch_flush_o), 0);
        chk("arst_drop", 32'(drop_cnt_o), 0);
        chk("arst_stall", 32'(stall_o), 0);
        chk("arst_bpu_pc", bpu_pc, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_valid", 32'(bpu_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
